// File: rtl/store_drain_buffer.sv
// Store write buffer: queues MEM-stage stores and drains them in order to a slower data bus.
// Pending stores are searchable by word address so loads can forward the youngest match.
module store_drain_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         memwrite,
  input  logic [AW-1:0]                dataaddr,
  input  logic [DW-1:0]                writedata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         bus_valid,
  output logic [AW-1:0]                bus_addr,
  output logic [DW-1:0]                bus_data,
  input  logic                         bus_ready,
  input  logic [AW-1:0]                lookup_addr,
  output logic                         lookup_hit,
  output logic [DW-1:0]                lookup_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] match;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic push;
  logic pop;
  logic lookup_lsb_unused;

  // Loads compare at word granularity, so the byte offset is irrelevant here.
  assign lookup_lsb_unused = ^lookup_addr[1:0];

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign bus_valid = !empty;

  assign pop  = bus_valid && bus_ready;
  assign push = memwrite && (!full || pop);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (memwrite && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // When full with a simultaneous pop, tail equals head: the push must win the valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail_q == PW'(i)) begin
          valid_q[i] <= 1'b1;
        end else if (pop && head_q == PW'(i)) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= dataaddr;
      data_q[tail_q] <= writedata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_q[gi] && (addr_q[gi][AW-1:2] == lookup_addr[AW-1:2]);
    end
  endgenerate

  // Scan oldest to youngest so the last hit found is the youngest pending store.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[head_q + PW'(i)]) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[head_q + PW'(i)];
      end
    end
  end

  assign bus_addr = bus_valid ? addr_q[head_q] : '0;
  assign bus_data = bus_valid ? data_q[head_q] : '0;

endmodule

// File: tb/tb_store_drain_buffer.sv
// Randomized and directed bench for store_drain_buffer, checked every cycle against a queue model.
module tb_store_drain_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataaddr = '0;
  logic [31:0] writedata = '0;
  logic        full, empty, overflow, bus_valid, lookup_hit;
  logic [2:0]  count;
  logic [31:0] bus_addr, bus_data, lookup_data;
  logic        bus_ready = 1'b0;
  logic [31:0] lookup_addr = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  logic m_ovf   = 1'b0;
  logic m_valid = 1'b0;
  logic [31:0] got[$];

  store_drain_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataaddr    (dataaddr),
    .writedata   (writedata),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .bus_valid   (bus_valid),
    .bus_addr    (bus_addr),
    .bus_data    (bus_data),
    .bus_ready   (bus_ready),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic [31:0] la, input logic rst);
    @(negedge clk);
    memwrite    = mw;
    dataaddr    = a;
    writedata   = d;
    bus_ready   = rdy;
    lookup_addr = la;
    reset       = rst;
  endtask

  task automatic idle(input logic rdy, input logic [31:0] la);
    drive(1'b0, 32'h0, 32'h0, rdy, la, 1'b0);
  endtask

  // Compare process: outputs vs. model, then advance the model with the inputs for the next edge.
  initial begin : cmp
    int   n;
    logic lh;
    logic [31:0] ld;
    logic pop, push;
    forever begin
      @(negedge clk);
      #1;
      if (m_valid) begin
        n  = mq.size();
        lh = 1'b0;
        ld = '0;
        foreach (mq[i]) begin
          if (mq[i].a[31:2] == lookup_addr[31:2]) begin
            lh = 1'b1;
            ld = mq[i].d;
          end
        end
        chk("count", {29'b0, count}, n);
        chk("full", full, n == DEPTH);
        chk("empty", empty, n == 0);
        chk("overflow", overflow, m_ovf);
        chk("bus_valid", bus_valid, n > 0);
        chk("bus_addr", bus_addr, (n > 0) ? mq[0].a : 32'h0);
        chk("bus_data", bus_data, (n > 0) ? mq[0].d : 32'h0);
        chk("lookup_hit", lookup_hit, lh);
        chk("lookup_data", lookup_data, ld);
      end
      if (reset) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_valid = 1'b1;
      end else if (m_valid) begin
        pop  = (mq.size() > 0) && bus_ready;
        push = memwrite && ((mq.size() < DEPTH) || pop);
        if (pop) begin
          $display("xfer addr=%h data=%h", mq[0].a, mq[0].d);
          void'(mq.pop_front());
        end
        if (memwrite && !push) m_ovf = 1'b1;
        if (push) mq.push_back('{a: dataaddr, d: writedata});
      end
    end
  end

  initial begin
    logic [31:0] exp_a [4];
    logic [2:0]  exp_c [4];
    logic        mw, rdy, rst;
    logic [31:0] a, la;
    int          bias;

    // Reset state
    drive(1'b0, 0, 0, 1'b0, 0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 0, 1'b1);
    idle(1'b0, 32'h0);
    #2;
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_data", bus_data, 0);
    chk("rst_hit", lookup_hit, 0);
    chk("rst_ldata", lookup_data, 0);

    // Single store, one-cycle latency to the bus
    drive(1'b1, 32'h54, 32'h7, 1'b1, 0, 1'b0);
    idle(1'b1, 32'h0);
    #2;
    chk("t1_valid", bus_valid, 1);
    chk("t1_addr", bus_addr, 32'h54);
    chk("t1_data", bus_data, 32'h7);
    idle(1'b1, 32'h0);
    #2;
    chk("t1_empty", empty, 1);
    chk("t1_count", {29'b0, count}, 0);

    // Fill with ready low and hold
    drive(1'b1, 32'h10, 32'hA, 1'b0, 0, 1'b0);
    drive(1'b1, 32'h14, 32'hB, 1'b0, 0, 1'b0);
    drive(1'b1, 32'h18, 32'hC, 1'b0, 0, 1'b0);
    drive(1'b1, 32'h1C, 32'hD, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 32'h0);
      #2;
      chk("t2_full", full, 1);
      chk("t2_count", {29'b0, count}, 4);
      chk("t2_hold_addr", bus_addr, 32'h10);
    end

    // Dropped store while full, then push+pop while full
    drive(1'b1, 32'h20, 32'hE, 1'b0, 0, 1'b0);
    drive(1'b1, 32'h24, 32'hF, 1'b1, 0, 1'b0);
    #2;
    chk("t3_ovf", overflow, 1);
    chk("t3_count", {29'b0, count}, 4);
    chk("t3_head", bus_addr, 32'h10);
    exp_a = '{32'h14, 32'h18, 32'h1C, 32'h24};
    exp_c = '{3'd4, 3'd3, 3'd2, 3'd1};
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 32'h0);
      #2;
      chk("t3_drain_addr", bus_addr, exp_a[i]);
      chk("t3_drain_count", {29'b0, count}, {29'b0, exp_c[i]});
    end
    idle(1'b1, 32'h0);
    #2;
    chk("t3_empty", empty, 1);
    chk("t3_ovf_sticky", overflow, 1);

    // Lookup: youngest of two matching entries
    drive(1'b0, 0, 0, 1'b0, 0, 1'b1);
    drive(1'b1, 32'h40, 32'h1, 1'b0, 0, 1'b0);
    drive(1'b1, 32'h40, 32'h2, 1'b0, 0, 1'b0);
    idle(1'b0, 32'h42);
    #2;
    chk("t4_hit", lookup_hit, 1);
    chk("t4_data", lookup_data, 32'h2);
    chk("t4_ovf_cleared", overflow, 0);
    idle(1'b1, 32'h42);
    #2;
    chk("t4_hit_popping", lookup_hit, 1);
    idle(1'b1, 32'h42);
    #2;
    chk("t4_data_one", lookup_data, 32'h2);
    idle(1'b1, 32'h42);
    #2;
    chk("t4_hit_gone", lookup_hit, 0);
    chk("t4_data_gone", lookup_data, 0);
    drive(1'b1, 32'h80, 32'h9, 1'b0, 32'h80, 1'b0);
    #2;
    chk("t4_push_not_hit", lookup_hit, 0);
    idle(1'b1, 32'h80);
    #2;
    chk("t4_hit_after_push", lookup_hit, 1);
    chk("t4_data_after_push", lookup_data, 32'h9);
    idle(1'b1, 32'h0);

    // Pointer wrap with continuous ready
    got.delete();
    for (int i = 0; i < 13; i++) begin
      if (i < 10) drive(1'b1, i * 4, i + 100, 1'b1, 0, 1'b0);
      else idle(1'b1, 32'h0);
      #2;
      chk("t5_count_le2", count <= 3'd2, 1);
      chk("t5_ovf", overflow, 0);
      if (bus_valid) got.push_back(bus_addr);
    end
    chk("t5_nxfer", got.size(), 10);
    foreach (got[i]) chk("t5_order", got[i], i * 4);

    // Reset mid-drain
    drive(1'b1, 32'h30, 32'h3, 1'b0, 0, 1'b0);
    drive(1'b1, 32'h34, 32'h4, 1'b0, 0, 1'b0);
    drive(1'b1, 32'h38, 32'h5, 1'b0, 32'h34, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 32'h34, 1'b1);
    idle(1'b0, 32'h34);
    #2;
    chk("t6_valid", bus_valid, 0);
    chk("t6_count", {29'b0, count}, 0);
    chk("t6_empty", empty, 1);
    chk("t6_hit", lookup_hit, 0);
    drive(1'b1, 32'h60, 32'h5, 1'b0, 0, 1'b0);
    idle(1'b1, 32'h0);
    #2;
    chk("t6_new_valid", bus_valid, 1);
    chk("t6_new_addr", bus_addr, 32'h60);

    // Randomized traffic with varying drain pressure
    for (int i = 0; i < 2000; i++) begin
      bias = i / 400;
      mw   = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 4) < bias);
      rst  = ($urandom_range(0, 199) == 0);
      a    = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      la   = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      drive(mw, a, $urandom, rdy, la, rst);
    end
    idle(1'b1, 32'h0);
    idle(1'b1, 32'h0);
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
